oam_dma_ctrl: RTL
=================

// Module: oam_dma_ctrl
// PURPOSE
//  Sequences sprite DMA (CPU write to $4014): halts the CPU, then copies XFER_LEN bytes from
//  CPU page {page,8'h00} into OAM as alternating read/write cycles.
//  Sits beside ppu_reg on the CPU bus and owns the OAM write port while busy.
//  Outside a transfer, the OAM port belongs to ppu_reg; the top level muxes on busy.
//  clk runs at CPU-cycle rate: one clk = one CPU cycle.
// PARAMETERS
//  XFER_LEN   256  bytes per transfer, 1..256; the index counter is 8 bits
//  ALIGN_EN   1    1: insert an alignment cycle so GETs land on even cycles; 0: never insert one
// PORTS
//  clk           in   1   system clock, one CPU cycle per edge
//  reset         in   1   asynchronous, active-high reset
//  dma_start     in   1   single-cycle strobe: the CPU wrote $4014
//  page_in       in   8   data written to $4014 (source high byte); sampled with dma_start
//  oam_base      in   8   current OAMADDR from ppu_reg; sampled with dma_start
//  mem_data_in   in   8   CPU-bus read data; valid in the GET cycle, captured at its closing edge
//  cpu_halt      out  1   RDY/halt to CPU: 1 for the whole transfer
//  mem_rd        out  1   bus read strobe, GET cycles only
//  mem_addr      out  16  bus read address {page,idx}
//  oam_addr_out  out  8   OAM write address
//  oam_data_out  out  8   OAM write data
//  oam_WE        out  1   OAM write enable, PUT cycles only
//  busy          out  1   1 from the HALT state through the last PUT
//  done          out  1   one-cycle pulse in the cycle after the last PUT
// BEHAVIOUR
//  Reset values
//   - state=IDLE; all outputs 0 (cpu_halt, mem_rd, oam_WE, busy, done, all buses).
//   - parity=0, idx=0.
//  Parity flop: toggles on every clk edge and is never cleared except by reset.
//  States: IDLE -> HALT -> [ALIGN] -> GET <-> PUT -> IDLE. Outputs are decoded from registered state.
//  IDLE
//   - dma_start=1: latch page_in->page and oam_base->obase, idx<=0, go to HALT.
//  HALT (1 cycle)
//   - cpu_halt=1, busy=1, no bus access.
//   - Next state: ALIGN if ALIGN_EN && parity==0; otherwise GET.
//  ALIGN (1 cycle): cpu_halt=1, busy=1, idle bus; next state GET.
//  GET
//   - mem_rd=1, mem_addr={page,idx}.
//   - Closing edge: data_q<=mem_data_in; next state PUT.
//  PUT
//   - oam_WE=1, oam_addr_out=obase+idx (8-bit, wraps mod 256), oam_data_out=data_q.
//   - Closing edge: if idx==XFER_LEN-1, go to IDLE and pulse done; otherwise idx<=idx+1, go to GET.
//  Latency
//   - cpu_halt rises on the edge after the dma_start edge.
//   - Halt length is 1+A+2*XFER_LEN cycles, A = 0 or 1: 513 or 514 at the default.
//   - cpu_halt and busy fall together with done rising.
//  Boundaries
//   - dma_start while busy, or in the done cycle, is ignored and the transfer continues unchanged.
//   - An OAM address wrap (obase+idx crossing 0xFF) is normal and is not flagged.
//   - mem_addr never leaves the latched page; idx does not carry into page.
//   - reset asserted mid-transfer: immediately IDLE, cpu_halt=0, oam_WE=0, no done pulse;
//     the partial OAM contents are left as written.
//   - dma_start held high for several cycles triggers exactly one transfer,
//     because later cycles are seen while busy.
// TESTING
//  1 page_in=0x02, 256-byte ramp at 0x0200+i=i, oam_base=0, start when HALT has parity=1
//    -> no ALIGN; 513 halt cycles; OAM[i]=i; done one cycle.
//  2 Same as 1 but start when HALT has parity=0 -> ALIGN inserted; 514 halt cycles;
//    first mem_rd is 2 cycles after cpu_halt rises.
//  3 oam_base=0xF0, source byte=~i -> OAM[(0xF0+i)&0xFF]=~i;
//    write 16 goes to addr 0x00; mem_addr stays 0x02xx.
//  4 Second dma_start (page 0x03) at cycle 100 of a page 0x02 transfer -> ignored;
//    all 256 reads come from 0x02xx; single done.
//  5 reset pulsed during GET of idx=0x40 -> outputs 0 asynchronously; no done;
//    a new start afterwards runs a full transfer.
//  6 XFER_LEN=4 build -> exactly 4 oam_WE pulses, halt 9 or 10 cycles.

Source files
------------

// File: rtl/oam_dma_if.sv
// Sprite-DMA controller bus bundle: CPU-side strobe/data, bus read port, OAM write port.
interface oam_dma_if;
    logic        dma_start;
    logic [7:0]  page_in;
    logic [7:0]  oam_base;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  oam_addr_out;
    logic [7:0]  oam_data_out;
    logic        oam_WE;
    logic        busy;
    logic        done;

    // DMA controller side
    modport master (
        input  dma_start, page_in, oam_base, mem_data_in,
        output cpu_halt, mem_rd, mem_addr, oam_addr_out, oam_data_out, oam_WE, busy, done
    );

    // CPU bus / PPU / environment side
    modport slave (
        output dma_start, page_in, oam_base, mem_data_in,
        input  cpu_halt, mem_rd, mem_addr, oam_addr_out, oam_data_out, oam_WE, busy, done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA ($4014): halts the CPU and copies XFER_LEN bytes from page {page,00}
// into OAM as alternating GET/PUT cycles. One clk is one CPU cycle.
module oam_dma_ctrl #(
    parameter int unsigned XFER_LEN = 256,
    parameter bit          ALIGN_EN = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.master bus
);

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned ADDR_W = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] GET   = 3'd3;
    localparam logic [2:0] PUT   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              parity_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        page_q, page_d;
    logic [7:0]        obase_q, obase_d;

    logic              cpu_halt_d, mem_rd_d, oam_we_d, busy_d, done_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        oam_addr_d, oam_data_d;

    // Free-running CPU-cycle parity; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= ~parity_q;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            page_q           <= '0;
            obase_q          <= '0;
            bus.cpu_halt     <= 1'b0;
            bus.mem_rd       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.oam_addr_out <= '0;
            bus.oam_data_out <= '0;
            bus.oam_WE       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            page_q           <= page_d;
            obase_q          <= obase_d;
            bus.cpu_halt     <= cpu_halt_d;
            bus.mem_rd       <= mem_rd_d;
            bus.mem_addr     <= mem_addr_d;
            bus.oam_addr_out <= oam_addr_d;
            bus.oam_data_out <= oam_data_d;
            bus.oam_WE       <= oam_we_d;
            bus.busy         <= busy_d;
            bus.done         <= done_d;
        end
    end

    // Next state plus output decode of the state being entered
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        obase_d = obase_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // a strobe landing in the done cycle belongs to the finished transfer
                if (bus.dma_start && !bus.done) begin
                    page_d  = bus.page_in;
                    obase_d = bus.oam_base;
                    idx_d   = '0;
                    state_d = HALT;
                end
            end
            HALT:    state_d = (ALIGN_EN && !parity_q) ? ALIGN : GET;
            ALIGN:   state_d = GET;
            GET:     state_d = PUT;
            PUT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = GET;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_halt_d = (state_d != IDLE);
        busy_d     = (state_d != IDLE);
        mem_rd_d   = (state_d == GET);
        oam_we_d   = (state_d == PUT);
        mem_addr_d = mem_rd_d ? {page_d, idx_d} : '0;
        oam_addr_d = oam_we_d ? (obase_d + idx_d) : '0;
        // PUT is only ever entered from GET, so the byte on the bus now is the one to write
        oam_data_d = oam_we_d ? bus.mem_data_in : '0;
    end

endmodule
